transpose_buffer: RTL

Parametrised, double-buffered N×N transpose memory between the row-wise 1D DCT stage and the column-wise 1D DCT stage. It accepts one row of N samples per handshake and emits one column of N samples per handshake. Two banks ping-pong, so block k+1 is written while block k drains, sustaining one row in and one column out per cycle. A per-block mode input can turn transposition off, so rows pass through unchanged.

---
 rtl/transpose_buffer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/transpose_buffer.sv
// Double-buffered NxN transpose memory: rows in, columns (or unchanged rows) out.
// Two banks ping-pong so one block fills while the previous one drains.
module transpose_buffer #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_transpose,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [1:0]     bank_full
);
    localparam int unsigned   AW   = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    bank_state_e    state_q [2];
    bank_state_e    state_d [2];
    logic [1:0]     mode_q, mode_d;
    logic           wr_sel_q, wr_sel_d;
    logic           rd_sel_q, rd_sel_d;
    logic [AW-1:0]  wr_row_q, wr_row_d;
    logic [AW-1:0]  rd_col_q, rd_col_d;
    logic           out_valid_q, out_valid_d;
    logic [N*W-1:0] out_data_q, out_data_d;
    logic [W-1:0]   mem_q [2][N][N];

    logic           wr_en;
    logic           rd_avail;
    logic           rd_en;
    logic [N*W-1:0] rd_beat;

    always_comb begin
        in_ready     = (state_q[wr_sel_q] == EMPTY) || (state_q[wr_sel_q] == FILLING);
        rd_avail     = (state_q[rd_sel_q] == FULL) || (state_q[rd_sel_q] == DRAINING);
        wr_en        = in_valid && in_ready;
        rd_en        = rd_avail && (!out_valid_q || out_ready);
        bank_full[0] = (state_q[0] == FULL) || (state_q[0] == DRAINING);
        bank_full[1] = (state_q[1] == FULL) || (state_q[1] == DRAINING);
    end

    always_comb begin
        rd_beat = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (mode_q[rd_sel_q]) begin
                rd_beat[k*W +: W] = mem_q[rd_sel_q][AW'(k)][rd_col_q];
            end else begin
                rd_beat[k*W +: W] = mem_q[rd_sel_q][rd_col_q][AW'(k)];
            end
        end
    end

    // Writes only touch EMPTY/FILLING banks and reads only FULL/DRAINING ones,
    // so the two state updates below never target the same bank.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_row_d    = wr_row_q;
        rd_col_d    = rd_col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (wr_en) begin
            wr_row_d = wr_row_q + 1'b1;
            if (wr_row_q == '0) begin
                mode_d[wr_sel_q]  = in_transpose;
                state_d[wr_sel_q] = FILLING;
            end
            if (wr_row_q == LAST) begin
                state_d[wr_sel_q] = FULL;
                wr_row_d          = '0;
                wr_sel_d          = !wr_sel_q;
            end
        end

        if (rd_en) begin
            out_data_d        = rd_beat;
            out_valid_d       = 1'b1;
            rd_col_d          = rd_col_q + 1'b1;
            state_d[rd_sel_q] = DRAINING;
            if (rd_col_q == LAST) begin
                state_d[rd_sel_q] = EMPTY;
                rd_col_d          = '0;
                rd_sel_d          = !rd_sel_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= '{EMPTY, EMPTY};
            mode_q      <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_row_q    <= '0;
            rd_col_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_row_q    <= wr_row_d;
            rd_col_q    <= rd_col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned k = 0; k < N; k++) begin
                mem_q[wr_sel_q][wr_row_q][AW'(k)] <= in_data[k*W +: W];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
